// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, ALUOp/funct encodings and the internal ALU op type.
package cpu_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned RegW = 5;

   localparam logic [1:0] AluOpAdd   = 2'b00;
   localparam logic [1:0] AluOpSub   = 2'b01;
   localparam logic [1:0] AluOpFunct = 2'b10;
   localparam logic [1:0] AluOpSlt   = 2'b11;

   localparam logic [5:0] FunctAdd = 6'h20;
   localparam logic [5:0] FunctSub = 6'h22;
   localparam logic [5:0] FunctAnd = 6'h24;
   localparam logic [5:0] FunctOr  = 6'h25;
   localparam logic [5:0] FunctSlt = 6'h2A;

   typedef enum logic [2:0] {
      AluAdd,
      AluSub,
      AluAnd,
      AluOr,
      AluSlt,
      AluZero
   } alu_op_e;

   // Unknown R-type funct maps to AluZero so the result is forced to 0.
   function automatic alu_op_e alu_decode(input logic [1:0] alu_op, input logic [5:0] funct);
      alu_op_e op;
      op = AluZero;
      case (alu_op)
         AluOpAdd: op = AluAdd;
         AluOpSub: op = AluSub;
         AluOpSlt: op = AluSlt;
         default: begin
            case (funct)
               FunctAdd: op = AluAdd;
               FunctSub: op = AluSub;
               FunctAnd: op = AluAnd;
               FunctOr:  op = AluOr;
               FunctSlt: op = AluSlt;
               default:  op = AluZero;
            endcase
         end
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu.sv
// Purely combinational 32-bit ALU: add/sub wrap, and, or, signed slt.
module alu
   import cpu_pkg::*;
(
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  alu_op_e         op,
   output logic [XLEN-1:0] result
);

   logic lt;

   always_comb begin
      lt     = $signed(a) < $signed(b);
      result = '0;
      case (op)
         AluAdd:  result = a + b;
         AluSub:  result = a - b;
         AluAnd:  result = a & b;
         AluOr:   result = a | b;
         AluSlt:  result = {{(XLEN-1){1'b0}}, lt};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, load-use hazard detect and the EX/MEM register.
module ex_stage
   import cpu_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] rg1,
   input  logic [XLEN-1:0] rg2,
   input  logic [XLEN-1:0] immVal,
   input  logic [RegW-1:0] destReg,
   input  logic [RegW-1:0] rdRg1,
   input  logic [RegW-1:0] rdRg2,
   input  logic [1:0]      AluOp,
   input  logic            AluSrc,
   input  logic            RegDst,
   input  logic            MemWr,
   input  logic            MemRd,
   input  logic            DataSrc,
   input  logic            WrReg,
   input  logic            wbWrReg,
   input  logic [RegW-1:0] wbDest,
   input  logic [XLEN-1:0] wbData,
   input  logic [RegW-1:0] idRs,
   input  logic [RegW-1:0] idRt,
   input  logic            flush,
   output logic            stall,
   output logic [XLEN-1:0] aluRes,
   output logic [XLEN-1:0] storeData,
   output logic [RegW-1:0] exDest,
   output logic            exMemWr,
   output logic            exMemRd,
   output logic            exDataSrc,
   output logic            exWrReg
);

   logic [XLEN-1:0] alu_res_q, store_data_q;
   logic [RegW-1:0] ex_dest_q;
   logic            mem_wr_q, mem_rd_q, data_src_q, wr_reg_q;

   logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_result;
   logic [RegW-1:0] wr_dest;
   alu_op_e         alu_op;

   assign wr_dest = RegDst ? destReg : rdRg2;
   assign alu_op  = alu_decode(AluOp, immVal[5:0]);

   // EX/MEM result is newer than MEM/WB, so it is checked first; $0 is never forwarded.
   always_comb begin
      fwd_a = rg1;
      if (wr_reg_q && (ex_dest_q != '0) && (ex_dest_q == rdRg1)) begin
         fwd_a = alu_res_q;
      end else if (wbWrReg && (wbDest != '0) && (wbDest == rdRg1)) begin
         fwd_a = wbData;
      end
      fwd_b = rg2;
      if (wr_reg_q && (ex_dest_q != '0) && (ex_dest_q == rdRg2)) begin
         fwd_b = alu_res_q;
      end else if (wbWrReg && (wbDest != '0) && (wbDest == rdRg2)) begin
         fwd_b = wbData;
      end
      op_b = AluSrc ? immVal : fwd_b;
   end

   assign stall = MemRd && WrReg && (wr_dest != '0) && ((wr_dest == idRs) || (wr_dest == idRt));

   alu u_alu (
      .a      (fwd_a),
      .b      (op_b),
      .op     (alu_op),
      .result (alu_result)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alu_res_q    <= '0;
         store_data_q <= '0;
         ex_dest_q    <= '0;
         mem_wr_q     <= 1'b0;
         mem_rd_q     <= 1'b0;
         data_src_q   <= 1'b0;
         wr_reg_q     <= 1'b0;
      end else if (flush) begin
         alu_res_q    <= '0;
         store_data_q <= '0;
         ex_dest_q    <= '0;
         mem_wr_q     <= 1'b0;
         mem_rd_q     <= 1'b0;
         data_src_q   <= 1'b0;
         wr_reg_q     <= 1'b0;
      end else begin
         alu_res_q    <= alu_result;
         store_data_q <= fwd_b;
         ex_dest_q    <= wr_dest;
         mem_wr_q     <= MemWr;
         mem_rd_q     <= MemRd;
         data_src_q   <= DataSrc;
         wr_reg_q     <= WrReg;
      end
   end

   assign aluRes    = alu_res_q;
   assign storeData = store_data_q;
   assign exDest    = ex_dest_q;
   assign exMemWr   = mem_wr_q;
   assign exMemRd   = mem_rd_q;
   assign exDataSrc = data_src_q;
   assign exWrReg   = wr_reg_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: ALU ops, forwarding, hazard, flush and reset.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] rg1, rg2, immVal, wbData;
   logic [4:0]  destReg, rdRg1, rdRg2, wbDest, idRs, idRt;
   logic [1:0]  AluOp;
   logic        AluSrc, RegDst, MemWr, MemRd, DataSrc, WrReg, wbWrReg, flush;
   logic        stall;
   logic [31:0] aluRes, storeData;
   logic [4:0]  exDest;
   logic        exMemWr, exMemRd, exDataSrc, exWrReg;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ex_stage dut (
      .clk       (clk),
      .rst       (rst),
      .rg1       (rg1),
      .rg2       (rg2),
      .immVal    (immVal),
      .destReg   (destReg),
      .rdRg1     (rdRg1),
      .rdRg2     (rdRg2),
      .AluOp     (AluOp),
      .AluSrc    (AluSrc),
      .RegDst    (RegDst),
      .MemWr     (MemWr),
      .MemRd     (MemRd),
      .DataSrc   (DataSrc),
      .WrReg     (WrReg),
      .wbWrReg   (wbWrReg),
      .wbDest    (wbDest),
      .wbData    (wbData),
      .idRs      (idRs),
      .idRt      (idRt),
      .flush     (flush),
      .stall     (stall),
      .aluRes    (aluRes),
      .storeData (storeData),
      .exDest    (exDest),
      .exMemWr   (exMemWr),
      .exMemRd   (exMemRd),
      .exDataSrc (exDataSrc),
      .exWrReg   (exWrReg)
   );

   task automatic idle_inputs();
      rg1 = 0; rg2 = 0; immVal = 0; wbData = 0;
      destReg = 0; rdRg1 = 0; rdRg2 = 0; wbDest = 0; idRs = 0; idRt = 0;
      AluOp = 2'b00; AluSrc = 0; RegDst = 0; MemWr = 0; MemRd = 0;
      DataSrc = 0; WrReg = 0; wbWrReg = 0; flush = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // R-type on registers with no forwarding hazard.
   task automatic rtype(input logic [31:0] a, input logic [31:0] b, input logic [5:0] funct,
                        input logic [4:0] rd, input logic wr);
      idle_inputs();
      rg1 = a; rg2 = b; immVal = {26'd0, funct}; AluOp = 2'b10;
      RegDst = 1; destReg = rd; WrReg = wr;
      tick();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 0;
      MemWr = 1; MemRd = 1; WrReg = 1; DataSrc = 1; rg1 = 32'h55; RegDst = 1; destReg = 5'd7;
      tick();
      checks++;
      if ({aluRes, storeData, exDest, exMemWr, exMemRd, exDataSrc, exWrReg} !== '0) begin
         errors++;
         $display("FAIL reset_state: got alu=%h st=%h dest=%0d ctl=%b%b%b%b want all 0",
                  aluRes, storeData, exDest, exMemWr, exMemRd, exDataSrc, exWrReg);
      end
      @(negedge clk);
      rst = 1;
      idle_inputs();
      tick();
   endtask

   task automatic test_rtype_add();
      rtype(32'd5, 32'd7, 6'h20, 5'd3, 1'b1);
      checks++;
      if (aluRes !== 32'd12 || exDest !== 5'd3 || exWrReg !== 1'b1) begin
         errors++;
         $display("FAIL rtype_add: got alu=%0d dest=%0d wr=%b want 12 3 1", aluRes, exDest, exWrReg);
      end
   endtask

   task automatic test_alu_ops();
      rtype(32'h0000F0F0, 32'h0000FF00, 6'h24, 5'd4, 1'b0);
      checks++;
      if (aluRes !== 32'h0000F000) begin
         errors++; $display("FAIL alu_and: got %h want 0000f000", aluRes);
      end
      rtype(32'h0000F0F0, 32'h0000FF00, 6'h25, 5'd4, 1'b0);
      checks++;
      if (aluRes !== 32'h0000FFF0) begin
         errors++; $display("FAIL alu_or: got %h want 0000fff0", aluRes);
      end
      rtype(32'd0, 32'd1, 6'h22, 5'd4, 1'b0);
      checks++;
      if (aluRes !== 32'hFFFFFFFF) begin
         errors++; $display("FAIL sub_wrap: got %h want ffffffff", aluRes);
      end
      rtype(32'hFFFFFFFF, 32'd1, 6'h2A, 5'd4, 1'b0);
      checks++;
      if (aluRes !== 32'd1) begin
         errors++; $display("FAIL slt_signed: got %h want 1", aluRes);
      end
      rtype(32'hFFFFFFFF, 32'd3, 6'h20, 5'd4, 1'b0);
      checks++;
      if (aluRes !== 32'd2) begin
         errors++; $display("FAIL add_wrap: got %h want 2", aluRes);
      end
      rtype(32'd9, 32'd3, 6'h21, 5'd4, 1'b0);
      checks++;
      if (aluRes !== 32'd0) begin
         errors++; $display("FAIL bad_funct: got %h want 0", aluRes);
      end
      // AluOp=11 slt with immediate: 1 < -1 is false.
      idle_inputs();
      rg1 = 32'd1; immVal = 32'hFFFFFFFF; AluSrc = 1; AluOp = 2'b11;
      tick();
      checks++;
      if (aluRes !== 32'd0) begin
         errors++; $display("FAIL slt_imm: got %h want 0", aluRes);
      end
   endtask

   task automatic test_forward();
      rtype(32'd5, 32'd7, 6'h20, 5'd3, 1'b1);
      idle_inputs();
      rdRg1 = 5'd3; rg1 = 32'd99; AluOp = 2'b01; AluSrc = 1; immVal = 32'd2;
      tick();
      checks++;
      if (aluRes !== 32'd10) begin
         errors++; $display("FAIL fwd_ex_a: got %0d want 10", aluRes);
      end
      // Priority: both stages target r3.
      rtype(32'd5, 32'd7, 6'h20, 5'd3, 1'b1);
      idle_inputs();
      rdRg1 = 5'd3; wbWrReg = 1; wbDest = 5'd3; wbData = 32'd50; AluSrc = 1;
      RegDst = 1; destReg = 5'd3; WrReg = 1;
      tick();
      checks++;
      if (aluRes !== 32'd12) begin
         errors++; $display("FAIL fwd_priority: got %0d want 12", aluRes);
      end
      idle_inputs();
      rdRg1 = 5'd0; rg1 = 32'd0; wbWrReg = 1; wbDest = 5'd3; wbData = 32'd50; AluSrc = 1;
      tick();
      checks++;
      if (aluRes !== 32'd0) begin
         errors++; $display("FAIL fwd_none_r0: got %0d want 0", aluRes);
      end
      // MEM/WB only (previous instruction did not write).
      idle_inputs();
      rdRg1 = 5'd6; rg1 = 32'd1; wbWrReg = 1; wbDest = 5'd6; wbData = 32'd50;
      AluSrc = 1; immVal = 32'd4;
      tick();
      checks++;
      if (aluRes !== 32'd54) begin
         errors++; $display("FAIL fwd_wb_a: got %0d want 54", aluRes);
      end
      // Forward B into both ALU operand and store data.
      rtype(32'd20, 32'd1, 6'h20, 5'd9, 1'b1);
      idle_inputs();
      rdRg2 = 5'd9; rg1 = 32'd100; rg2 = 32'd7; AluOp = 2'b01; MemWr = 1;
      tick();
      checks++;
      if (aluRes !== 32'd79 || storeData !== 32'd21 || exMemWr !== 1'b1) begin
         errors++;
         $display("FAIL fwd_ex_b: got alu=%0d st=%0d mw=%b want 79 21 1", aluRes, storeData, exMemWr);
      end
      // A write to $0 is never forwarded.
      rtype(32'd70, 32'd7, 6'h20, 5'd0, 1'b1);
      idle_inputs();
      rdRg1 = 5'd0; rg1 = 32'd5; AluSrc = 1;
      tick();
      checks++;
      if (aluRes !== 32'd5) begin
         errors++; $display("FAIL fwd_r0: got %0d want 5", aluRes);
      end
   endtask

   task automatic test_stall();
      idle_inputs();
      MemRd = 1; WrReg = 1; RegDst = 0; rdRg2 = 5'd8; idRt = 5'd8; idRs = 5'd1;
      flush = 1;
      #1;
      checks++;
      if (stall !== 1'b1) begin
         errors++; $display("FAIL stall_rt: got %b want 1", stall);
      end
      idRt = 5'd9; idRs = 5'd9;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         errors++; $display("FAIL stall_nomatch: got %b want 0", stall);
      end
      idRs = 5'd8;
      MemRd = 0;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         errors++; $display("FAIL stall_nomemrd: got %b want 0", stall);
      end
      MemRd = 1; rdRg2 = 5'd0; idRs = 5'd0;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         errors++; $display("FAIL stall_r0: got %b want 0", stall);
      end
      idle_inputs();
      #1;
   endtask

   task automatic test_flush_and_reset();
      idle_inputs();
      MemWr = 1; MemRd = 1; DataSrc = 1; WrReg = 1; RegDst = 1; destReg = 5'd5;
      rg1 = 32'd3; rg2 = 32'd4;
      tick();
      checks++;
      if ({exMemWr, exMemRd, exDataSrc, exWrReg} !== 4'b1111 || exDest !== 5'd5 ||
          storeData !== 32'd4) begin
         errors++;
         $display("FAIL ctl_pass: got ctl=%b%b%b%b dest=%0d st=%0d want 1111 5 4",
                  exMemWr, exMemRd, exDataSrc, exWrReg, exDest, storeData);
      end
      flush = 1;
      tick();
      checks++;
      if ({exMemWr, exMemRd, exDataSrc, exWrReg} !== 4'b0000 || aluRes !== 32'd0) begin
         errors++;
         $display("FAIL flush_bubble: got ctl=%b%b%b%b alu=%0d want 0000 0",
                  exMemWr, exMemRd, exDataSrc, exWrReg, aluRes);
      end
      flush = 0;
      tick();
      #2;
      rst = 0;
      #1;
      checks++;
      if ({aluRes, storeData, exDest, exMemWr, exMemRd, exDataSrc, exWrReg} !== '0) begin
         errors++;
         $display("FAIL async_reset: got alu=%h st=%h dest=%0d ctl=%b%b%b%b want all 0",
                  aluRes, storeData, exDest, exMemWr, exMemRd, exDataSrc, exWrReg);
      end
      #1;
      rst = 1;
      rtype(32'd1, 32'd2, 6'h20, 5'd2, 1'b1);
      checks++;
      if (aluRes !== 32'd3 || exDest !== 5'd2 || exWrReg !== 1'b1) begin
         errors++;
         $display("FAIL post_reset: got alu=%0d dest=%0d wr=%b want 3 2 1", aluRes, exDest, exWrReg);
      end
   endtask

   initial begin
      rst = 0;
      idle_inputs();
      test_reset();
      test_rtype_add();
      test_alu_ops();
      test_forward();
      test_stall();
      test_flush_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 clk  in  1  rising-edge clock for the EX/MEM output register.
REQ-002 rst  in  1  asynchronous, active-low reset; rst=0 clears all registered outputs immediately.
REQ-003 rg1, rg2  in  32 each  rs/rt operand values from the ID/EX register.
REQ-004 immVal  in  32  sign-extended immediate; [5:0] carries funct for R-type.
REQ-005 destReg  in  5  rd field; rdRg1, rdRg2  in  5 each  rs/rt register numbers.
REQ-006 AluOp  in  2, AluSrc  in  1, RegDst  in  1  execute controls.
REQ-007 MemWr, MemRd, DataSrc, WrReg  in  1 each  later-stage controls.
REQ-008 wbWrReg  in  1, wbDest  in  5, wbData  in  32  MEM/WB write-back port, used for forwarding.
REQ-009 idRs, idRt  in  5 each  source registers of the instruction currently in ID.
REQ-010 flush  in  1  squashes the instruction in EX.
REQ-011 stall  out  1  combinational load-use hazard request to the IF/ID and ID/EX stages.
REQ-012 aluRes, storeData  out  32 each  registered EX/MEM data.
REQ-013 exDest  out  5, exMemWr, exMemRd, exDataSrc, exWrReg  out  1 each  registered EX/MEM controls.

Function
REQ-014 Write register: RegDst=1 selects destReg; RegDst=0 selects rdRg2.
REQ-015 Forward A priority: EX/MEM (exWrReg=1, exDest!=0, exDest==rdRg1) gives aluRes; otherwise MEM/WB (wbWrReg=1, wbDest!=0, wbDest==rdRg1) gives wbData; otherwise rg1.
REQ-016 Forward B uses the same rule against rdRg2; the result is storeData-next, and is also the ALU operand B when AluSrc=0.
REQ-017 ALU operand B: AluSrc=1 selects immVal; AluSrc=0 selects forwarded B.
REQ-018 AluOp 00 add, 01 sub, 11 slt; 10 decodes funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
REQ-019 Any other funct with AluOp 10 produces aluRes=0.
REQ-020 add/sub wrap modulo 2^32; no overflow flag.
REQ-021 slt is a signed compare and gives 32'd1 or 32'd0.
REQ-022 Latency: one cycle; the EX/MEM outputs update on the rising clk edge after the inputs are presented.
REQ-023 flush=1 at an edge loads a bubble: exMemWr, exMemRd, exWrReg and exDataSrc = 0; data outputs are don't-care, and 0 is loaded.
REQ-024 stall=1 iff MemRd=1, WrReg=1, the selected write register !=0, and it equals idRs or idRt.
REQ-025 stall does not alter this block's own register update.
REQ-026 flush does not suppress stall.
REQ-027 Register $0 is never forwarded.
REQ-028 When EX/MEM and MEM/WB both match a source, EX/MEM wins.

Reset
REQ-029 While rst=0, all registered outputs are 0 regardless of clk.
REQ-030 Reset asserted mid-instruction discards that instruction; no partial state remains.
REQ-031 The first edge after rst rises captures normally.

Structure
REQ-032 ALU op encodings, funct constants and the 32/5 width constants are placed in shared package cpu_pkg.
REQ-033 The ALU is one sub-module, alu (a, b, op in; result out), and is purely combinational.
REQ-034 Forwarding muxes, hazard compare and the EX/MEM register are kept in ex_stage.

Verification
REQ-035 R-type add, funct 0x20, rg1=5, rg2=7, RegDst=1, destReg=3, WrReg=1 -> next edge: aluRes=12, exDest=3, exWrReg=1.
REQ-036 EX/MEM forward: previous aluRes=12, exDest=3; now rdRg1=3, rg1=99, sub of 2 -> aluRes=10.
REQ-037 EX/MEM vs MEM/WB priority: both target 3, wbData=50, exDest=3 with aluRes=12 -> operand A=12; with rdRg1=0 and rg1=0 -> no forward.
REQ-038 Load-use: MemRd=1, WrReg=1, RegDst=0, rdRg2=8, idRt=8 -> stall=1; idRs=idRt=9 -> stall=0.
REQ-039 slt signed compare: rg1=0xFFFFFFFF, rg2=1, funct 0x2A -> aluRes=1.
REQ-040 flush and mid-cycle reset: flush=1 with MemWr=1 -> exMemWr=0 after the edge; rst pulsed low between edges -> all outputs 0 immediately.
